cpu16_icache: RTL

- Direct-mapped, read-only instruction cache between the cpu16 instruction port and a slower shared instruction memory.
- CPU side mimics a synchronous-read RAM: address presented in cycle N; data plus ready in cycle N+1 on hit.
- On miss: ready stays low, whole line filled over a req/ack memory handshake, then the re-presented address hits.
- Includes a flush input for invalidation after code loads.

---
 rtl/cpu16_icache.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/cpu16_icache.sv
// Direct-mapped, read-only instruction cache for the cpu16 instruction port.
//
// The CPU side behaves like a synchronous-read RAM. An address is presented in
// cycle N, and on a hit the data arrives with cpu_rdy in cycle N+1. On a miss,
// the whole line is fetched in order over a req/ack handshake. The CPU
// re-presents the same address, and that address hits once the fill is done.
//
// Ports:
//   clk, reset      clock; synchronous active-high reset
//   cpu_addr        word address from the CPU (combinational pc_next)
//   cpu_req         lookup request
//   cpu_data        instruction for the address sampled at the previous edge
//   cpu_rdy         cpu_data valid this cycle
//   flush           single-cycle pulse; invalidates all lines
//   mem_addr        backing-memory word address
//   mem_req         backing-memory read request, held until acked
//   mem_ack         one-cycle ack; mem_rdata valid in the same cycle
//   mem_rdata       backing-memory read data
module cpu16_icache #(
  parameter int unsigned LINE_BITS = 2,
  parameter int unsigned IDX_BITS  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_req,
  output logic [15:0] cpu_data,
  output logic        cpu_rdy,
  input  logic        flush,
  output logic [15:0] mem_addr,
  output logic        mem_req,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata
);

  localparam int unsigned AW    = LINE_BITS + IDX_BITS;  // data array address width
  localparam int unsigned LW    = 16 - LINE_BITS;        // line address width
  localparam int unsigned TW    = 16 - AW;               // tag width
  localparam int unsigned Lines = 2 ** IDX_BITS;
  localparam int unsigned Words = 2 ** AW;

  typedef enum logic [1:0] {StIdle, StFill, StSettle} state_e;

  state_e               state_q, state_d;
  logic                 lookup_q, lookup_d;
  logic [LW-1:0]        la_q, la_d;       // line part of the lookup address
  logic [LW-1:0]        fill_q, fill_d;   // line being filled
  logic [LINE_BITS-1:0] cnt_q, cnt_d;
  logic                 flush_pend_q, flush_pend_d;
  logic [Lines-1:0]     valid_q, valid_d;
  logic [TW-1:0]        tag_q [Lines];
  logic [15:0]          data_mem [Words];
  logic [15:0]          rdata_q;

  logic                 arr_we, arr_re, tag_we, hit;
  logic [IDX_BITS-1:0]  la_idx, fill_idx;
  logic [TW-1:0]        la_tag, fill_tag;
  logic [15:0]          fill_addr;

  assign la_idx    = la_q[IDX_BITS-1:0];
  assign la_tag    = la_q[LW-1:IDX_BITS];
  assign fill_idx  = fill_q[IDX_BITS-1:0];
  assign fill_tag  = fill_q[LW-1:IDX_BITS];
  assign fill_addr = {fill_q, cnt_q};
  assign hit       = lookup_q && valid_q[la_idx] && (tag_q[la_idx] == la_tag);

  always_comb begin
    state_d      = state_q;
    lookup_d     = 1'b0;
    la_d         = la_q;
    fill_d       = fill_q;
    cnt_d        = cnt_q;
    flush_pend_d = flush_pend_q;
    valid_d      = valid_q;
    arr_we       = 1'b0;
    arr_re       = 1'b0;
    tag_we       = 1'b0;
    cpu_rdy      = 1'b0;
    mem_req      = 1'b0;
    mem_addr     = '0;

    unique case (state_q)
      StIdle: begin
        cpu_rdy = hit;
        if (lookup_q && !hit) begin
          state_d = StFill;
          fill_d  = la_q;
          cnt_d   = '0;
        end else if (cpu_req) begin
          lookup_d = 1'b1;
          la_d     = cpu_addr[15:LINE_BITS];
          arr_re   = 1'b1;
        end
      end
      StFill: begin
        mem_req  = 1'b1;
        mem_addr = fill_addr;
        if (mem_ack) begin
          arr_we = 1'b1;
          cnt_d  = cnt_q + LINE_BITS'(1);
          if (cnt_q == {LINE_BITS{1'b1}}) begin
            tag_we  = 1'b1;
            state_d = StSettle;
            if (!flush_pend_q) valid_d[fill_idx] = 1'b1;
          end
        end
      end
      StSettle: begin
        // The last fill write has landed, so reading the array from here is safe.
        state_d = StIdle;
        if (cpu_req) begin
          lookup_d = 1'b1;
          la_d     = cpu_addr[15:LINE_BITS];
          arr_re   = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // A flush during a fill also poisons the line being fetched.
    if (flush) begin
      valid_d = '0;
      if (state_q == StFill) flush_pend_d = 1'b1;
    end
    if (state_d != StFill) flush_pend_d = 1'b0;

    cpu_data = cpu_rdy ? rdata_q : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      lookup_q     <= 1'b0;
      la_q         <= '0;
      fill_q       <= '0;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
      valid_q      <= '0;
    end else begin
      state_q      <= state_d;
      lookup_q     <= lookup_d;
      la_q         <= la_d;
      fill_q       <= fill_d;
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
      valid_q      <= valid_d;
    end
  end

  // Tags are only meaningful when the matching valid bit is set, so they need no reset.
  always_ff @(posedge clk) begin
    if (tag_we) tag_q[fill_idx] <= fill_tag;
  end

  // Single-port style data array with a registered read.
  always_ff @(posedge clk) begin
    if (arr_we) data_mem[fill_addr[AW-1:0]] <= mem_rdata;
    if (arr_re) rdata_q <= data_mem[cpu_addr[AW-1:0]];
  end

endmodule
